// File: rtl/eth_rx.sv
// RGMII receive path: DDR pad capture, preamble/SFD strip, one-byte hold for tlast,
// CRC-32 residue / length / RX_ER checking with bad-frame flag on the last beat.

module eth_rx_iddr (
   input  logic clk,
   input  logic d,
   output logic q1,
   output logic q2
);
   logic rise_r;
   logic fall_r;

   // Same-edge pipelined: both phases of one rxc period appear together on q1/q2
   always_ff @(posedge clk) begin
      rise_r <= d;
      q1     <= rise_r;
      q2     <= fall_r;
   end

   always_ff @(negedge clk) begin
      fall_r <= d;
   end
endmodule

module eth_rx #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_ctl,
   input  logic [3:0] rxd,
   output logic       tvalid,
   output logic [7:0] tdata,
   output logic       tlast,
   output logic       tuser,
   output logic       frame_ok,
   output logic       frame_err
);
   localparam int NUM_LANES = 5;
   localparam int CTL       = 4;

   localparam logic [2:0] S_WAIT_IDLE = 3'd0;
   localparam logic [2:0] S_IDLE      = 3'd1;
   localparam logic [2:0] S_PRE       = 3'd2;
   localparam logic [2:0] S_DATA      = 3'd3;
   localparam logic [2:0] S_DROP      = 3'd4;

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   logic [NUM_LANES-1:0] pad;
   logic [NUM_LANES-1:0] q_rise;
   logic [NUM_LANES-1:0] q_fall;

   assign pad = {rx_ctl, rxd};

   eth_rx_iddr u_iddr [NUM_LANES-1:0] (
      .clk (clk),
      .d   (pad),
      .q1  (q_rise),
      .q2  (q_fall)
   );

   // rx byte stage; left out of reset so the FSM sees live pad data right after rst
   logic [7:0] rb_byte;
   logic       rb_dv;
   logic       rb_er;

   always_ff @(posedge clk) begin
      rb_byte <= {q_fall[3:0], q_rise[3:0]};
      rb_dv   <= q_rise[CTL];
      rb_er   <= q_rise[CTL] ^ q_fall[CTL];
   end

   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   logic [2:0]  state;
   logic [15:0] len;
   logic [31:0] crc;
   logic        er_seen;
   logic [7:0]  hold;
   logic        hold_vld;
   logic        bad;

   assign bad = (crc != CRC_RESIDUE) | (len < 16'(MIN_LEN)) | er_seen;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_WAIT_IDLE;
         len       <= '0;
         crc       <= CRC_INIT;
         er_seen   <= 1'b0;
         hold      <= '0;
         hold_vld  <= 1'b0;
         tvalid    <= 1'b0;
         tdata     <= '0;
         tlast     <= 1'b0;
         tuser     <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         tvalid    <= 1'b0;
         tdata     <= '0;
         tlast     <= 1'b0;
         tuser     <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;

         case (state)
            S_WAIT_IDLE: begin
               if (!rb_dv) state <= S_IDLE;
            end

            S_IDLE, S_PRE: begin
               if (!rb_dv)
                  state <= S_IDLE;
               else if (rb_byte == 8'h55)
                  state <= S_PRE;
               else if (rb_byte == 8'hD5) begin
                  state    <= S_DATA;
                  len      <= '0;
                  crc      <= CRC_INIT;
                  er_seen  <= 1'b0;
                  hold_vld <= 1'b0;
               end else
                  state <= S_DROP;
            end

            S_DATA: begin
               if (rb_dv) begin
                  if (hold_vld) begin
                     tvalid <= 1'b1;
                     tdata  <= hold;
                  end
                  // A byte beyond MAX_LEN turns the held MAX_LEN-th byte into a bad last beat
                  if (hold_vld && len == 16'(MAX_LEN)) begin
                     tlast     <= 1'b1;
                     tuser     <= 1'b1;
                     frame_err <= 1'b1;
                     hold_vld  <= 1'b0;
                     state     <= S_DROP;
                  end else begin
                     hold     <= rb_byte;
                     hold_vld <= 1'b1;
                     len      <= len + 16'd1;
                     crc      <= crc_next(crc, rb_byte);
                     er_seen  <= er_seen | rb_er;
                  end
               end else begin
                  hold_vld <= 1'b0;
                  state    <= S_IDLE;
                  if (hold_vld) begin
                     tvalid    <= 1'b1;
                     tdata     <= hold;
                     tlast     <= 1'b1;
                     tuser     <= bad;
                     frame_ok  <= ~bad;
                     frame_err <= bad;
                  end else
                     frame_err <= 1'b1;
               end
            end

            S_DROP: begin
               if (!rb_dv) state <= S_IDLE;
            end

            default: state <= S_WAIT_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eth_rx.sv
// Self-checking bench for eth_rx: drives RGMII DDR pads, compares the output stream
// against a frame-level model (FCS recomputed from payload, length/ER rules).
`timescale 1ns/1ps

module tb_eth_rx;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_ctl = 1'b0;
   logic [3:0] rxd = 4'h0;
   logic       tvalid, tlast, tuser, frame_ok, frame_err;
   logic [7:0] tdata;

   eth_rx #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_ctl    (rx_ctl),
      .rxd       (rxd),
      .tvalid    (tvalid),
      .tdata     (tdata),
      .tlast     (tlast),
      .tuser     (tuser),
      .frame_ok  (frame_ok),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [7:0] q_data[$];
   bit         q_last[$];
   bit         q_user[$];
   int         q_cyc[$];
   int         n_ok = 0, n_ferr = 0, n_mis = 0;

   logic [7:0] fr[$];
   logic [7:0] fx[$];
   int b_q, b_ok, b_err, b_mis;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: collect beats and check pulse alignment with the tlast beat
   always @(negedge clk) begin
      if (tvalid === 1'b1) begin
         q_data.push_back(tdata);
         q_last.push_back(tlast);
         q_user.push_back(tuser);
         q_cyc.push_back(cyc);
      end
      if (frame_ok === 1'b1) n_ok <= n_ok + 1;
      if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
      if ((frame_ok === 1'b1) != (tvalid === 1'b1 && tlast === 1'b1 && tuser === 1'b0))
         n_mis <= n_mis + 1;
      else if (tvalid === 1'b1 && tlast === 1'b1 && tuser === 1'b1 && frame_err !== 1'b1)
         n_mis <= n_mis + 1;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] b, input bit dv, input bit er, input bit do_rst);
      rxd    = b[3:0];
      rx_ctl = dv;
      if (do_rst) rst = 1'b1;
      @(posedge clk); #1;
      rxd    = b[7:4];
      rx_ctl = dv ^ er;
      if (do_rst) rst = 1'b0;
      @(negedge clk); #1;
   endtask

   // Bit-serial reflected CRC-32 of fr[0..n-1], register value before final inversion
   function automatic logic [31:0] crc_of(input int n);
      logic [31:0] c;
      bit fb;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ fr[i][k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      return c;
   endfunction

   function automatic bit fcs_ok();
      int n;
      n = fr.size();
      if (n < 4) return 1'b0;
      return {fr[n-1], fr[n-2], fr[n-3], fr[n-4]} == ~crc_of(n - 4);
   endfunction

   task automatic build(input int plen);
      logic [31:0] fcs;
      fr.delete();
      for (int i = 0; i < plen; i++) fr.push_back(8'($urandom));
      fcs = ~crc_of(plen);
      for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
   endtask

   task automatic send_frame(input int pre, input int er_idx, input int rst_idx,
                             input int ifg, input bit ext);
      for (int i = 0; i < pre; i++) drive(8'h55, 1'b1, 1'b0, 1'b0);
      drive(8'hD5, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < fr.size(); i++) begin
         drive(fr[i], 1'b1, i == er_idx, i == rst_idx);
         if (i == rst_idx)
            check("rst_outputs_low", {tvalid, tlast, tuser, frame_ok, frame_err}, 0);
      end
      for (int i = 0; i < ifg; i++) drive(8'h0F, 1'b0, ext && i == 0, 1'b0);
   endtask

   task automatic snap();
      b_q   = q_data.size();
      b_ok  = n_ok;
      b_err = n_ferr;
      b_mis = n_mis;
   endtask

   task automatic expect_frame(input string tag, input bit er_any);
      int n, n_exp, got, dmis, lastcnt, usermid;
      bit bad;
      n     = fr.size();
      n_exp = (n > MAX_LEN) ? MAX_LEN : n;
      bad   = (n < MIN_LEN) || (n > MAX_LEN) || er_any || !fcs_ok();
      got   = q_data.size() - b_q;
      dmis = 0; lastcnt = 0; usermid = 0;
      for (int i = 0; i < got && i < n_exp; i++) begin
         if (q_data[b_q+i] !== fr[i]) dmis++;
         if (q_last[b_q+i]) lastcnt++;
         if (q_user[b_q+i] && !q_last[b_q+i]) usermid++;
      end
      check({tag, ".beats"}, got, n_exp);
      check({tag, ".data_errs"}, dmis, 0);
      check({tag, ".tlast_count"}, lastcnt, (n_exp > 0) ? 1 : 0);
      check({tag, ".tuser_mid"}, usermid, 0);
      if (got > 0) begin
         check({tag, ".tlast_on_last"}, q_last[b_q+got-1], 1);
         check({tag, ".tuser"}, q_user[b_q+got-1], bad);
      end
      check({tag, ".frame_ok"}, n_ok - b_ok, bad ? 0 : 1);
      check({tag, ".frame_err"}, n_ferr - b_err, bad ? 1 : 0);
      check({tag, ".pulse_align"}, n_mis - b_mis, 0);
   endtask

   initial begin
      int got, dmis, lastcnt, li, plen, er_idx;

      for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
      check("reset_outputs", {tvalid, tdata, tlast, tuser, frame_ok, frame_err}, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);

      // 1: good minimum frame
      build(60); snap(); send_frame(7, -1, -1, 12, 1'b0); expect_frame("t1_good", 1'b0);
      // 2: corrupted FCS
      build(60); fr[63] = fr[63] ^ 8'h01;
      snap(); send_frame(7, -1, -1, 12, 1'b0); expect_frame("t2_crc", 1'b0);
      // 3: RX_ER on byte 20
      build(60); snap(); send_frame(7, -1, -1, 12, 1'b0);
      fr.delete();
      build(60); snap(); send_frame(7, 20, -1, 12, 1'b0); expect_frame("t3_er", 1'b1);
      // 4: short, exact max, oversize
      build(36); snap(); send_frame(7, -1, -1, 12, 1'b0); expect_frame("t4_short", 1'b0);
      build(MAX_LEN - 4); snap(); send_frame(7, -1, -1, 12, 1'b0); expect_frame("t4_max", 1'b0);
      build(1596); snap(); send_frame(7, -1, -1, 12, 1'b0); expect_frame("t4_long", 1'b0);
      // SFD immediately followed by end of frame
      fr.delete(); snap(); send_frame(7, -1, -1, 12, 1'b0); expect_frame("t_sfd_only", 1'b0);

      // 5: reset mid-frame A, then good frame B
      build(100); fx = fr; snap();
      send_frame(7, -1, 30, 12, 1'b0);
      got = q_data.size() - b_q;
      dmis = 0; lastcnt = 0;
      for (int i = 0; i < got; i++) begin
         if (i >= fx.size() || q_data[b_q+i] !== fx[i]) dmis++;
         if (q_last[b_q+i]) lastcnt++;
      end
      check("t5_A.tlast_count", lastcnt, 0);
      check("t5_A.prefix_errs", dmis, 0);
      check("t5_A.cut_short", got < 30, 1);
      check("t5_A.no_pulses", (n_ok - b_ok) + (n_ferr - b_err), 0);
      build(60); snap(); send_frame(7, -1, -1, 12, 1'b0); expect_frame("t5_B", 1'b0);

      // 6: two good frames with a 1-byte IFG
      build(60); fx = fr; snap();
      send_frame(7, -1, -1, 1, 1'b0);
      build(60);
      send_frame(7, -1, -1, 12, 1'b0);
      got = q_data.size() - b_q;
      dmis = 0; lastcnt = 0; li = -1;
      for (int i = 0; i < got; i++) begin
         if (i < 64) begin
            if (q_data[b_q+i] !== fx[i]) dmis++;
         end else if (i < 128) begin
            if (q_data[b_q+i] !== fr[i-64]) dmis++;
         end
         if (q_last[b_q+i]) begin
            lastcnt++;
            if (li < 0) li = i;
         end
      end
      check("t6.beats", got, 128);
      check("t6.data_errs", dmis, 0);
      check("t6.tlast_count", lastcnt, 2);
      check("t6.frame_ok", n_ok - b_ok, 2);
      check("t6.frame_err", n_ferr - b_err, 0);
      if (li >= 0 && li + 1 < got)
         check("t6.tvalid_gap", (q_cyc[b_q+li+1] - q_cyc[b_q+li]) > 1, 1);
      else
         check("t6.first_tlast_found", li, 63);

      // Randomized frames: varied length, optional bit flip, RX_ER, carrier extend in IFG
      for (int k = 0; k < 8; k++) begin
         plen = $urandom_range(30, 160);
         build(plen);
         if ($urandom_range(0, 2) == 0)
            fr[$urandom_range(0, fr.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
         er_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, fr.size() - 1) : -1;
         snap();
         send_frame($urandom_range(1, 7), er_idx, -1, $urandom_range(1, 6), 1'($urandom));
         for (int i = 0; i < 6; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
         expect_frame($sformatf("rnd%0d", k), er_idx >= 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
